alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Arbitrates one shared ALU between two requesters: port 0 is the main issue path, port 1 is the address/branch helper.
- Accepts valid/ready requests and drives the ALU operand/opcode inputs from a registered issue stage.
- Captures the ALU result and overflow into a per-requester response slot that holds until acknowledged.
- Sits between the decode/issue logic and the ALU; the ALU itself stays purely combinational.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- OPW, 5, width of the ALU opcode field.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 always wins.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle when also valid
- req0_op / req1_op  input  OPW  ALU opcode
- req0_a / req1_a  input  WIDTH  operand 1
- req0_b / req1_b  input  WIDTH  operand 2 (immediate already selected by requester)
- req0_sv / req1_sv  input  2  shift amount for the scaled-add opcode
- alu_in1  output  WIDTH  to ALU in1
- alu_in2  output  WIDTH  to ALU in2
- alu_op  output  OPW  to ALU alu_op
- alu_sv  output  2  to ALU sv
- alu_imm_mux  output  1  constant 0
- alu_result  input  WIDTH  from ALU result
- alu_overflow  input  1  from ALU overflow
- rsp0_valid / rsp1_valid  output  1  response available
- rsp0_ready / rsp1_ready  input  1  response consumed
- rsp0_result / rsp1_result  output  WIDTH  captured result
- rsp0_overflow / rsp1_overflow  output  1  captured overflow

Behaviour:
- Reset (async, rst_n low): all outputs 0; issue stage empty; RR pointer favours port 0; response slots empty. Reset mid-operation discards in-flight and held results.
- busy_i = in-flight(i) OR (rsp_i_valid AND NOT rsp_i_ready).
- At most one outstanding request per port.
- Eligible_i = req_i_valid AND NOT busy_i.
- Grant:
  - If only one port is eligible, it wins.
  - If both are eligible: FIXED_PRIO=1 gives port 0; otherwise the port not granted most recently wins, and the pointer updates only on an actual grant.
- req_i_ready = grant_i (combinational); no grant when neither port is eligible.
- Accept cycle N: opcode, operands, sv and port id are registered into the issue stage; the issue stage is marked valid.
- Cycle N+1: alu_in1/in2/op/sv driven from the issue stage. When the issue stage is empty, ALU outputs are driven to op=0, operands=0.
- End of N+1: {alu_overflow, alu_result} registered into the owning response slot; rsp_i_valid=1 from N+2.
- Latency is 2 cycles accept-to-response.
- Throughput is 1 accept per cycle overall; back-to-back accepts alternate ports when both are contending.
- Response slot holds result and overflow stable until the cycle rsp_i_valid AND rsp_i_ready; it then clears unless a new result lands the same edge, in which case the new result is loaded.
- A port may issue its next request in the same cycle its response is consumed.
- Issue-stage valid is cleared each cycle unless a new grant occurs; there is no stall, because the response slot is guaranteed free by the busy rule.
- Values are passed unmodified; no width conversion. Overflow is the ALU bit passed through without interpretation.

Test Plan:
- Single request: reset, then port 0 requests op=0, a=5, b=7 at cycle 2 -> req0_ready=1 at cycle 2; alu_in1=5, alu_in2=7, alu_op=0 at cycle 3; rsp0_valid=1 with result 12, overflow 0 at cycle 4.
- Contention, round-robin: both ports valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; port1 op=1, a=3, b=5 returns result 0xFFFFFFFE with overflow 1.
- Contention, fixed priority: FIXED_PRIO=1 with both ports valid -> port 0 is granted whenever not busy; port 1 is granted only in cycles where port 0 is busy.
- Backpressure: rsp0_ready=0 for 5 cycles after a result -> rsp0_result stays stable, req0_ready stays 0, port 1 is still served. Raising rsp0_ready with req0_valid high -> same-cycle drain and accept.
- Scaled add: op=9, a=0x100, b=4, sv=2 -> result 0x110. op=8, b=0xDEAD -> result 0xDEAD.
- Reset mid-flight: assert rst_n=0 between accept and response -> all rsp_valid=0 immediately; after release, no stale response appears and grants resume from port 0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// slave = arbiter view, master = requester/ALU environment view.
interface alu_share_arb_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_sv;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_sv;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [OPW-1:0]   alu_op;
  logic [1:0]       alu_sv;
  logic             alu_imm_mux;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_overflow;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_overflow;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_sv,
    input  req1_valid, req1_op, req1_a, req1_b, req1_sv,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_op, alu_sv, alu_imm_mux,
    input  alu_result, alu_overflow,
    output rsp0_valid, rsp0_result, rsp0_overflow,
    output rsp1_valid, rsp1_result, rsp1_overflow,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_sv,
    output req1_valid, req1_op, req1_a, req1_b, req1_sv,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_op, alu_sv, alu_imm_mux,
    output alu_result, alu_overflow,
    input  rsp0_valid, rsp0_result, rsp0_overflow,
    input  rsp1_valid, rsp1_result, rsp1_overflow,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-port arbiter for one shared combinational ALU: registered issue
// stage feeding the ALU, per-port response slots held until consumed.
module alu_share_arb #(
  parameter int WIDTH      = 32,
  parameter int OPW        = 5,
  parameter int FIXED_PRIO = 0
) (
  input logic           clk,
  input logic           rst_n,
  alu_share_arb_if.slave bus
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       busy;
  logic [1:0]       elig;
  logic [1:0]       grant;

  logic             iss_valid;
  logic             iss_port;
  logic [OPW-1:0]   iss_op;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;
  logic [1:0]       iss_sv;
  logic             last_grant;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ovf;
  logic [WIDTH-1:0] rsp_result [2];

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // Busy/eligible per port and the arbitration decision.
  always_comb begin
    busy  = '0;
    elig  = '0;
    grant = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      busy[i] = (iss_valid && (iss_port == 1'(i))) || (rsp_valid[i] && !rsp_ready[i]);
      elig[i] = req_valid[i] && !busy[i];
    end
    if (elig == 2'b11)
      grant = ((FIXED_PRIO != 0) || last_grant) ? 2'b01 : 2'b10;
    else
      grant = elig;
  end

  // Issue stage: capture the granted request, zero when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid  <= 1'b0;
      iss_port   <= 1'b0;
      iss_op     <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
      iss_sv     <= '0;
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      iss_valid  <= 1'b1;
      iss_port   <= grant[1];
      iss_op     <= grant[1] ? bus.req1_op : bus.req0_op;
      iss_a      <= grant[1] ? bus.req1_a  : bus.req0_a;
      iss_b      <= grant[1] ? bus.req1_b  : bus.req0_b;
      iss_sv     <= grant[1] ? bus.req1_sv : bus.req0_sv;
      last_grant <= grant[1];
    end else begin
      iss_valid  <= 1'b0;
      iss_port   <= 1'b0;
      iss_op     <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
      iss_sv     <= '0;
    end
  end

  // Response slots: a landing result wins over the consume-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= '0;
      rsp_ovf       <= '0;
      rsp_result[0] <= '0;
      rsp_result[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (iss_valid && (iss_port == 1'(i))) begin
          rsp_valid[i]  <= 1'b1;
          rsp_result[i] <= bus.alu_result;
          rsp_ovf[i]    <= bus.alu_overflow;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.req0_ready    = grant[0];
  assign bus.req1_ready    = grant[1];
  assign bus.alu_in1       = iss_a;
  assign bus.alu_in2       = iss_b;
  assign bus.alu_op        = iss_op;
  assign bus.alu_sv        = iss_sv;
  assign bus.alu_imm_mux   = 1'b0;
  assign bus.rsp0_valid    = rsp_valid[0];
  assign bus.rsp0_result   = rsp_result[0];
  assign bus.rsp0_overflow = rsp_ovf[0];
  assign bus.rsp1_valid    = rsp_valid[1];
  assign bus.rsp1_result   = rsp_result[1];
  assign bus.rsp1_overflow = rsp_ovf[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench: a round-robin and a fixed-priority instance share the
// same requester stimulus; each has its own behavioural ALU.
module tb_alu_share_arb;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_share_arb_if #(.WIDTH(WIDTH), .OPW(OPW)) bus_rr ();
  alu_share_arb_if #(.WIDTH(WIDTH), .OPW(OPW)) bus_fp ();

  alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr));
  alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp));

  always #5 clk = ~clk;

  // ALU model: 0 add (carry), 1 sub (borrow), 8 pass b, 9 a + (b << sv).
  function automatic logic [WIDTH:0] alu_model(input logic [OPW-1:0] op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] sv);
    logic [WIDTH:0] r;
    case (op)
      5'd0:    r = {1'b0, a} + {1'b0, b};
      5'd1:    r = {(a < b), a - b};
      5'd8:    r = {1'b0, b};
      5'd9:    r = {1'b0, a} + {1'b0, b << sv};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {bus_rr.alu_overflow, bus_rr.alu_result} =
    alu_model(bus_rr.alu_op, bus_rr.alu_in1, bus_rr.alu_in2, bus_rr.alu_sv);
  assign {bus_fp.alu_overflow, bus_fp.alu_result} =
    alu_model(bus_fp.alu_op, bus_fp.alu_in1, bus_fp.alu_in2, bus_fp.alu_sv);

  assign bus_fp.req0_valid = bus_rr.req0_valid;
  assign bus_fp.req0_op    = bus_rr.req0_op;
  assign bus_fp.req0_a     = bus_rr.req0_a;
  assign bus_fp.req0_b     = bus_rr.req0_b;
  assign bus_fp.req0_sv    = bus_rr.req0_sv;
  assign bus_fp.req1_valid = bus_rr.req1_valid;
  assign bus_fp.req1_op    = bus_rr.req1_op;
  assign bus_fp.req1_a     = bus_rr.req1_a;
  assign bus_fp.req1_b     = bus_rr.req1_b;
  assign bus_fp.req1_sv    = bus_rr.req1_sv;
  assign bus_fp.rsp0_ready = bus_rr.rsp0_ready;
  assign bus_fp.rsp1_ready = bus_rr.rsp1_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [OPW-1:0] op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] sv);
    bus_rr.req0_valid = v;
    bus_rr.req0_op    = op;
    bus_rr.req0_a     = a;
    bus_rr.req0_b     = b;
    bus_rr.req0_sv    = sv;
  endtask

  task automatic set_req1(input logic v, input logic [OPW-1:0] op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] sv);
    bus_rr.req1_valid = v;
    bus_rr.req1_op    = op;
    bus_rr.req1_a     = a;
    bus_rr.req1_b     = b;
    bus_rr.req1_sv    = sv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_req0(1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    set_req1(1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    bus_rr.rsp0_ready = 1'b0;
    bus_rr.rsp1_ready = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_rsp0_valid", 64'(bus_rr.rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(bus_rr.rsp1_valid), 64'd0);
    check("rst_alu_op",     64'(bus_rr.alu_op), 64'd0);
    check("rst_alu_in1",    64'(bus_rr.alu_in1), 64'd0);
    check("rst_imm_mux",    64'(bus_rr.alu_imm_mux), 64'd0);
    check("rst_req0_ready", 64'(bus_rr.req0_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // Single request, 2-cycle latency
    set_req0(1'b1, 5'd0, 32'd5, 32'd7, 2'd0);
    #1;
    check("t1_req0_ready", 64'(bus_rr.req0_ready), 64'd1);
    check("t1_req1_ready", 64'(bus_rr.req1_ready), 64'd0);
    step();
    bus_rr.req0_valid = 1'b0;
    check("t1_alu_in1", 64'(bus_rr.alu_in1), 64'd5);
    check("t1_alu_in2", 64'(bus_rr.alu_in2), 64'd7);
    check("t1_alu_op",  64'(bus_rr.alu_op), 64'd0);
    check("t1_rsp0_valid_early", 64'(bus_rr.rsp0_valid), 64'd0);
    step();
    check("t1_rsp0_valid", 64'(bus_rr.rsp0_valid), 64'd1);
    check("t1_rsp0_result", 64'(bus_rr.rsp0_result), 64'd12);
    check("t1_rsp0_ovf", 64'(bus_rr.rsp0_overflow), 64'd0);

    // Backpressure on port 0 while port 1 keeps being served
    set_req0(1'b1, 5'd9, 32'h100, 32'd4, 2'd2);
    set_req1(1'b1, 5'd1, 32'd3, 32'd5, 2'd0);
    bus_rr.rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp0_valid",  64'(bus_rr.rsp0_valid), 64'd1);
      check("bp_rsp0_result", 64'(bus_rr.rsp0_result), 64'd12);
      check("bp_req0_ready",  64'(bus_rr.req0_ready), 64'd0);
      check("bp_req1_ready",  64'(bus_rr.req1_ready), 64'((i % 2) == 0));
      if (i >= 2 && (i % 2) == 0) begin
        check("bp_rsp1_valid",  64'(bus_rr.rsp1_valid), 64'd1);
        check("bp_rsp1_result", 64'(bus_rr.rsp1_result), 64'hFFFF_FFFE);
        check("bp_rsp1_ovf",    64'(bus_rr.rsp1_overflow), 64'd1);
      end
      step();
    end
    bus_rr.req1_valid = 1'b0;
    bus_rr.rsp0_ready = 1'b1;
    #1;
    check("drain_accept_req0_ready", 64'(bus_rr.req0_ready), 64'd1);
    step();
    bus_rr.req0_valid = 1'b0;
    check("sa_rsp0_valid_cleared", 64'(bus_rr.rsp0_valid), 64'd0);
    check("sa_alu_op",  64'(bus_rr.alu_op), 64'd9);
    check("sa_alu_in1", 64'(bus_rr.alu_in1), 64'h100);
    check("sa_alu_in2", 64'(bus_rr.alu_in2), 64'd4);
    check("sa_alu_sv",  64'(bus_rr.alu_sv), 64'd2);
    check("sa_rsp1_valid", 64'(bus_rr.rsp1_valid), 64'd1);
    step();
    check("sa_rsp0_valid",  64'(bus_rr.rsp0_valid), 64'd1);
    check("sa_rsp0_result", 64'(bus_rr.rsp0_result), 64'h110);
    check("sa_rsp1_drained", 64'(bus_rr.rsp1_valid), 64'd0);

    // Pass-through of operand b
    set_req0(1'b1, 5'd8, 32'd0, 32'hDEAD, 2'd0);
    #1;
    check("pb_req0_ready", 64'(bus_rr.req0_ready), 64'd1);
    step();
    bus_rr.req0_valid = 1'b0;
    bus_rr.rsp0_ready = 1'b0;
    step();
    check("pb_rsp0_valid",  64'(bus_rr.rsp0_valid), 64'd1);
    check("pb_rsp0_result", 64'(bus_rr.rsp0_result), 64'hDEAD);

    // Reset mid-flight with a held result on port 0
    set_req1(1'b1, 5'd1, 32'd3, 32'd5, 2'd0);
    bus_rr.rsp1_ready = 1'b0;
    #1;
    check("mr_req1_ready", 64'(bus_rr.req1_ready), 64'd1);
    step();
    bus_rr.req1_valid = 1'b0;
    check("mr_inflight_op", 64'(bus_rr.alu_op), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mr_rsp0_valid", 64'(bus_rr.rsp0_valid), 64'd0);
    check("mr_rsp1_valid", 64'(bus_rr.rsp1_valid), 64'd0);
    check("mr_alu_op",     64'(bus_rr.alu_op), 64'd0);
    check("mr_alu_in1",    64'(bus_rr.alu_in1), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    bus_rr.rsp0_ready = 1'b1;
    bus_rr.rsp1_ready = 1'b1;
    repeat (2) step();
    check("mr_no_stale0", 64'(bus_rr.rsp0_valid), 64'd0);
    check("mr_no_stale1", 64'(bus_rr.rsp1_valid), 64'd0);

    // Contention: grants alternate 0,1,0,1 starting from port 0
    set_req0(1'b1, 5'd0, 32'd1, 32'd2, 2'd0);
    set_req1(1'b1, 5'd1, 32'd3, 32'd5, 2'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_req0_ready", 64'(bus_rr.req0_ready), 64'((i % 2) == 0));
      check("rr_req1_ready", 64'(bus_rr.req1_ready), 64'((i % 2) == 1));
      check("fp_req0_ready", 64'(bus_fp.req0_ready), 64'((i % 2) == 0));
      if (i == 2 || i == 4) begin
        check("rr_rsp0_valid",  64'(bus_rr.rsp0_valid), 64'd1);
        check("rr_rsp0_result", 64'(bus_rr.rsp0_result), 64'd3);
      end
      if (i == 3 || i == 5) begin
        check("rr_rsp1_valid",  64'(bus_rr.rsp1_valid), 64'd1);
        check("rr_rsp1_result", 64'(bus_rr.rsp1_result), 64'hFFFF_FFFE);
        check("rr_rsp1_ovf",    64'(bus_rr.rsp1_overflow), 64'd1);
      end
      step();
    end
    bus_rr.req0_valid = 1'b0;
    bus_rr.req1_valid = 1'b0;
    repeat (3) step();

    // Port 0 granted last, then both contend: round-robin vs fixed priority
    bus_rr.req0_valid = 1'b1;
    #1;
    check("pr_solo_rr_req0", 64'(bus_rr.req0_ready), 64'd1);
    check("pr_solo_fp_req0", 64'(bus_fp.req0_ready), 64'd1);
    step();
    bus_rr.req0_valid = 1'b0;
    step();
    bus_rr.req0_valid = 1'b1;
    bus_rr.req1_valid = 1'b1;
    #1;
    check("pr_rr_req1_wins", 64'(bus_rr.req1_ready), 64'd1);
    check("pr_rr_req0_loses", 64'(bus_rr.req0_ready), 64'd0);
    check("pr_fp_req0_wins", 64'(bus_fp.req0_ready), 64'd1);
    check("pr_fp_req1_loses", 64'(bus_fp.req1_ready), 64'd0);
    step();
    #1;
    check("pr_rr_next_req0", 64'(bus_rr.req0_ready), 64'd1);
    check("pr_rr_next_req1", 64'(bus_rr.req1_ready), 64'd0);
    check("pr_fp_next_req1", 64'(bus_fp.req1_ready), 64'd1);
    check("pr_fp_next_req0", 64'(bus_fp.req0_ready), 64'd0);
    step();
    bus_rr.req0_valid = 1'b0;
    bus_rr.req1_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
